// File: rtl/alu_issue_if.sv
// Issue-side bundle for alu_issue_unit: instruction handshake,
// external ALU operands/result, retire status and debug read port.
interface alu_issue_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs;
  logic [2:0]        in_rt;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              done;
  logic [DATA_W-1:0] wb_data;
  logic              zero_flag;
  logic              busy;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt,
    output in_use_imm, in_imm,
    output alu_result, alu_zero, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_ctrl,
    input  done, wb_data, zero_flag, busy, dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt,
    input  in_use_imm, in_imm,
    input  alu_result, alu_zero, dbg_addr,
    output in_ready, alu_a, alu_b, alu_ctrl,
    output done, wb_data, zero_flag, busy, dbg_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Four-state issue unit: read operands, drive external ALU,
// capture result, write back to a small register file.
module alu_issue_unit #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [2:0]        r_rd;
  logic [2:0]        r_rs;
  logic [2:0]        r_rt;
  logic              r_use_imm;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_rf [REG_N];
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_ctrl;
  logic [DATA_W-1:0] r_res;
  logic              r_zero;
  logic [DATA_W-1:0] r_wb;
  logic              r_zf;
  logic              r_done;

  logic              w_acc;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_dbg_val;

  assign w_acc = bus.in_valid && (r_state == S_IDLE);

  // r0 is hard-wired to zero on every read path
  assign w_rs_val  = (r_rs == 3'd0) ? '0 : r_rf[r_rs];
  assign w_rt_val  = (r_rt == 3'd0) ? '0 : r_rf[r_rt];
  assign w_dbg_val = (bus.dbg_addr == 3'd0) ? '0 : r_rf[bus.dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_ctrl    <= '0;
      r_res     <= '0;
      r_zero    <= 1'b0;
      r_wb      <= '0;
      r_zf      <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < REG_N; i++) r_rf[i] <= '0;
    end else begin
      r_done <= (r_state == S_WB);
      if (w_acc) begin
        r_op      <= bus.in_op;
        r_rd      <= bus.in_rd;
        r_rs      <= bus.in_rs;
        r_rt      <= bus.in_rt;
        r_use_imm <= bus.in_use_imm;
        r_imm     <= bus.in_imm;
      end
      if (r_state == S_READ) begin
        r_alu_a <= w_rs_val;
        r_alu_b <= r_use_imm ? r_imm : w_rt_val;
        r_ctrl  <= r_op;
      end
      if (r_state == S_EXEC) begin
        r_res  <= bus.alu_result;
        r_zero <= bus.alu_zero;
      end
      if (r_state == S_WB) begin
        if (r_rd != 3'd0) r_rf[r_rd] <= r_res;
        r_wb <= r_res;
        r_zf <= r_zero;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_ctrl  = r_ctrl;
  assign bus.done      = r_done;
  assign bus.wb_data   = r_wb;
  assign bus.zero_flag = r_zf;
  assign bus.dbg_data  = w_dbg_val;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU
// (000 add, 001 a-b, 010 b-a, 011 and, 100 or, 101 xor, 110 not a, 111 b).
module tb_alu_issue_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n_done;

  alu_issue_if #(.DATA_W(16)) bus ();

  alu_issue_unit #(.DATA_W(16), .REG_N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(
    input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return b - a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 16'h0000);

  always @(posedge clk) if (bus.done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op,
                       input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic ui,
                       input logic [15:0] imm, input logic [15:0] ewb,
                       input logic ez);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_use_imm = ui;
    bus.in_imm     = imm;
    bus.dbg_addr   = rd;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    n = 0;
    while (!bus.done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_wb"}, bus.wb_data, ewb);
    chk({tag, "_zf"}, bus.zero_flag, ez);
    chk({tag, "_ctl"}, bus.alu_ctrl, op);
    chk({tag, "_dbg"}, bus.dbg_data, (rd == 0) ? 16'h0 : ewb);
    @(posedge clk);
    #1;
    chk({tag, "_dn0"}, bus.done, 0);
  endtask

  task automatic rd_dbg(input string tag, input logic [2:0] a,
                        input logic [15:0] exp);
    bus.dbg_addr = a;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  initial begin
    int n;
    int d0;
    n_chk  = 0;
    n_fail = 0;
    n_done = 0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rd      = '0;
    bus.in_rs      = '0;
    bus.in_rt      = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.dbg_addr   = 3'd3;
    rst = 1'b1;
    #12;
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wb", bus.wb_data, 0);
    chk("rst_zf", bus.zero_flag, 0);
    chk("rst_a", bus.alu_a, 0);
    chk("rst_b", bus.alu_b, 0);
    chk("rst_ctl", bus.alu_ctrl, 0);
    chk("rst_dbg", bus.dbg_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_rdy", bus.in_ready, 1);

    issue("ld1", 3'd7, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 1'b0);
    issue("ld2", 3'd7, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 16'h0003, 1'b0);
    issue("sub", 3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0002, 1'b0);
    chk("sub_a", bus.alu_a, 16'h0005);
    chk("sub_b", bus.alu_b, 16'h0003);
    issue("rsb", 3'd2, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000, 16'hFFFE, 1'b0);
    issue("wrap", 3'd0, 3'd6, 3'd4, 3'd2, 1'b0, 16'h0000, 16'h0001, 1'b0);
    issue("zr0", 3'd1, 3'd0, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h0000, 1'b1);
    rd_dbg("r0", 3'd0, 16'h0000);
    rd_dbg("r3", 3'd3, 16'h0002);
    rd_dbg("r4", 3'd4, 16'hFFFE);

    // back-pressure: valid stays high across two instructions
    d0 = n_done;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_op      = 3'd7;
    bus.in_rd      = 3'd5;
    bus.in_use_imm = 1'b1;
    bus.in_imm     = 16'h00AA;
    @(posedge clk);
    #1;
    bus.in_rd  = 3'd7;
    bus.in_imm = 16'h0011;
    chk("bp_rdy1", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("bp_rdy2", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("bp_rdy3", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("bp_done1", bus.done, 1);
    chk("bp_wb1", bus.wb_data, 16'h00AA);
    chk("bp_rdy4", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_acc2", bus.busy, 1);
    n = 0;
    while (!bus.done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_lat2", n, 3);
    chk("bp_wb2", bus.wb_data, 16'h0011);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_npulse", n_done - d0, 2);
    rd_dbg("bp_r5", 3'd5, 16'h00AA);
    rd_dbg("bp_r7", 3'd7, 16'h0011);

    // reset while the instruction sits in EXEC
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = n_done;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.in_rd    = 3'd5;
    bus.in_rs    = 3'd1;
    bus.in_rt    = 3'd2;
    bus.in_use_imm = 1'b1;
    bus.in_imm   = 16'h0008;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ex_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("ex_rst_busy", bus.busy, 0);
    chk("ex_rst_rdy", bus.in_ready, 1);
    chk("ex_rst_b", bus.alu_b, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("ex_nodone", n_done - d0, 0);
    chk("ex_idle", bus.busy, 0);
    rd_dbg("ex_r5", 3'd5, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter DATA_W, default 16, datapath width.
REQ-002 Parameter REG_N, default 8, register file depth; address width 3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  unit can accept an instruction.
REQ-007 in_op  input  3  ALU operation code, same encoding as the ALU's ALUCTRL (000 add … 111 pass b).
REQ-008 in_rd / in_rs / in_rt  input  3 each  destination, source-a, source-b register addresses.
REQ-009 in_use_imm  input  1  select in_imm instead of reg[rt] as operand b.
REQ-010 in_imm  input  DATA_W  immediate operand.
REQ-011 alu_a / alu_b  output  DATA_W each  registered operands to the ALU.
REQ-012 alu_ctrl  output  3  registered ALUCTRL to the ALU.
REQ-013 alu_result  input  DATA_W  ALU result (combinational from alu_a/alu_b/alu_ctrl).
REQ-014 alu_zero  input  1  ALU zero flag.
REQ-015 done  output  1  one-cycle pulse: instruction retired.
REQ-016 wb_data  output  DATA_W  retired result, valid while done=1, held until next retire.
REQ-017 zero_flag  output  1  status: zero flag of last retired instruction.
REQ-018 busy  output  1  high whenever state != IDLE.
REQ-019 dbg_addr  input  3 / dbg_data  output  DATA_W  combinational read of reg[dbg_addr].

Function
REQ-020 FSM states IDLE, READ, EXEC, WB; IDLE->READ on in_valid&in_ready; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-021 in_ready = 1 only in IDLE; accept latches in_op, in_rd, in_rs, in_rt, in_use_imm, in_imm.
REQ-022 On READ edge: alu_a <= reg[rs]; alu_b <= use_imm ? imm : reg[rt]; alu_ctrl <= op; these hold unchanged through EXEC and WB.
REQ-023 On EXEC edge: capture alu_result and alu_zero into internal result/zero registers.
REQ-024 On WB edge: reg[rd] <= captured result unless rd==0; wb_data <= captured result; zero_flag <= captured zero; done=1 during the following IDLE cycle (registered pulse).
REQ-025 Register 0 reads as 0 always; writes to it are dropped but zero_flag and wb_data still update.
REQ-026 Latency: accept at edge N -> done high in cycle after edge N+3; throughput one instruction per 4 cycles; in_valid held during busy is ignored, not queued.
REQ-027 Read-after-write: a following instruction reads the already-written rd value (write at WB edge precedes next READ).
REQ-028 Arithmetic wraps modulo 2^DATA_W (performed by ALU; unit adds no saturation or carry).
REQ-029 dbg_data reflects a write on the cycle after the WB edge.
REQ-030 done accepted simultaneously with a new in_valid in IDLE: both occur; new instruction accepted that edge.

Reset
REQ-031 rst asserted: state=IDLE, all registers r0..r7=0, alu_a=alu_b=0, alu_ctrl=000, wb_data=0, zero_flag=0, done=0, busy=0, in_ready=1, immediately (asynchronous).
REQ-032 rst mid-operation discards the in-flight instruction; no done pulse and no register write occur.

Verification
REQ-033 Reset: assert rst in any state -> all outputs at REQ-031 values same cycle; in_ready=1 after release.
REQ-034 Load: op=111, use_imm=1, imm=0x0005, rd=1 -> done 4 cycles after accept, wb_data=0x0005, zero_flag=0, dbg r1=0x0005; load r2=0x0003 likewise.
REQ-035 Subtract/wrap: op=001 rd=3 rs=1 rt=2 -> r3=0x0002; op=010 rd=4 rs=1 rt=2 -> r4=0xFFFE.
REQ-036 Zero and r0: op=001 rd=0 rs=1 rt=1 -> wb_data=0x0000, zero_flag=1, dbg r0=0x0000.
REQ-037 Back-pressure: in_valid held high with two instructions -> in_ready low in READ/EXEC/WB; second accepted on edge where done=1; exactly two done pulses.
REQ-038 Reset in EXEC after op=000 rd=5 -> no done, r5=0, state IDLE.
